// File: rtl/srio_user_pkg.sv
`default_nettype none
// ============================================================================
// srio_user_pkg : SRIO user-port packet types, arbiter states, size helper (rev 1.0)
// ============================================================================
package srio_user_pkg;

   localparam logic [3:0] FTYPE_NWRITE   = 4'h5;
   localparam logic [3:0] FTYPE_SWRITE   = 4'h6;
   localparam logic [3:0] TTYPE_NWRITE   = 4'h4;
   localparam logic [3:0] TTYPE_NWRITE_R = 4'h5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_XFER  = 2'd2
   } arb_state_e;

   // tsize is byte count minus one; payload beats are 8 bytes wide.
   function automatic logic [9:0] beats_from_tsize(input logic [11:0] tsize);
      return 10'(tsize >> 3) + 10'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/srio_nwr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// rr_pick : combinational round-robin winner search starting at ptr (rev 1.0)
// ============================================================================
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [IDX_W-1:0]   idx_o,
   output logic               valid_o
);

   int p;

   // Scan offsets high to low so the smallest offset from ptr wins last.
   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      valid_o = |req_i;
      p       = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         p = int'(ptr_i) + k;
         if (p >= NUM_REQ) begin
            p = p - NUM_REQ;
         end
         if (req_i[IDX_W'(p)]) begin
            idx_o = IDX_W'(p);
         end
      end
      if (valid_o) begin
         grant_o[idx_o] = 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/srio_nwr_arbiter.sv
`default_nettype none
// ============================================================================
// srio_nwr_arbiter : round-robin sharing of the SRIO NWRITE user port (rev 1.0)
// ============================================================================
module srio_nwr_arbiter
   import srio_user_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic                    log_clk,
   input  logic                    log_rst_n,
   input  logic                    nwr_ready_in,
   input  logic                    nwr_busy_in,
   input  logic [NUM_REQ-1:0]      req_valid_i,
   input  logic [34*NUM_REQ-1:0]   req_addr_i,
   input  logic [4*NUM_REQ-1:0]    req_ftype_i,
   input  logic [4*NUM_REQ-1:0]    req_ttype_i,
   input  logic [12*NUM_REQ-1:0]   req_tsize_i,
   input  logic [64*NUM_REQ-1:0]   req_tdata_i,
   input  logic [NUM_REQ-1:0]      req_tvalid_i,
   input  logic [NUM_REQ-1:0]      req_tlast_i,
   input  logic [8*NUM_REQ-1:0]    req_tkeep_i,
   output logic [NUM_REQ-1:0]      req_tready_o,
   output logic [NUM_REQ-1:0]      grant_o,
   output logic [33:0]             user_addr_o,
   output logic [3:0]              user_ftype_o,
   output logic [3:0]              user_ttype_o,
   output logic [11:0]             user_tsize_o,
   output logic [63:0]             user_tdata_o,
   output logic [7:0]              user_tkeep_o,
   output logic                    user_tvalid_o,
   output logic                    user_tlast_o,
   input  logic                    user_tready_in,
   output logic                    len_err_o,
   output logic                    pkt_done_o
);

   localparam int IDX_W = $clog2(NUM_REQ);

   arb_state_e         state_q, state_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [IDX_W-1:0]   gidx_q, gidx_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [33:0]        addr_q, addr_d;
   logic [3:0]         ftype_q, ftype_d;
   logic [3:0]         ttype_q, ttype_d;
   logic [11:0]        tsize_q, tsize_d;
   logic [8:0]         beat_q, beat_d;
   logic               ovf_q, ovf_d;
   logic               len_err_q, len_err_d;
   logic               pkt_done_q, pkt_done_d;

   logic [33:0]        addr_a  [NUM_REQ];
   logic [3:0]         ftype_a [NUM_REQ];
   logic [3:0]         ttype_a [NUM_REQ];
   logic [11:0]        tsize_a [NUM_REQ];
   logic [63:0]        tdata_a [NUM_REQ];
   logic [7:0]         tkeep_a [NUM_REQ];

   logic [NUM_REQ-1:0] pick_oh;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_any;
   logic               in_xfer;
   logic               hs;
   logic [9:0]         exp_beats;
   logic [9:0]         beat_inc;

   assign in_xfer = (state_q == ST_XFER);

   generate
      for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
         assign addr_a[i]       = req_addr_i[i*34 +: 34];
         assign ftype_a[i]      = req_ftype_i[i*4 +: 4];
         assign ttype_a[i]      = req_ttype_i[i*4 +: 4];
         assign tsize_a[i]      = req_tsize_i[i*12 +: 12];
         assign tdata_a[i]      = req_tdata_i[i*64 +: 64];
         assign tkeep_a[i]      = req_tkeep_i[i*8 +: 8];
         assign req_tready_o[i] = in_xfer && (gidx_q == IDX_W'(i)) && user_tready_in;
      end
   endgenerate

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .req_i   (req_valid_i),
      .ptr_i   (ptr_q),
      .grant_o (pick_oh),
      .idx_o   (pick_idx),
      .valid_o (pick_any)
   );

   // Payload is a straight mux of the granted requester, forced quiet outside XFER.
   assign user_tvalid_o = in_xfer && req_tvalid_i[gidx_q];
   assign user_tlast_o  = in_xfer && req_tlast_i[gidx_q];
   assign user_tdata_o  = in_xfer ? tdata_a[gidx_q] : '0;
   assign user_tkeep_o  = in_xfer ? tkeep_a[gidx_q] : '0;

   assign hs        = user_tvalid_o && user_tready_in;
   assign exp_beats = beats_from_tsize(tsize_q);
   assign beat_inc  = {1'b0, beat_q} + 10'd1;

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      gidx_d     = gidx_q;
      grant_d    = grant_q;
      addr_d     = addr_q;
      ftype_d    = ftype_q;
      ttype_d    = ttype_q;
      tsize_d    = tsize_q;
      beat_d     = beat_q;
      ovf_d      = ovf_q;
      len_err_d  = 1'b0;
      pkt_done_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (nwr_ready_in && !nwr_busy_in && pick_any) begin
               state_d = ST_GRANT;
               gidx_d  = pick_idx;
               grant_d = pick_oh;
               addr_d  = addr_a[pick_idx];
               ftype_d = ftype_a[pick_idx];
               ttype_d = ttype_a[pick_idx];
               tsize_d = tsize_a[pick_idx];
               beat_d  = '0;
               ovf_d   = 1'b0;
            end
         end
         ST_GRANT: begin
            state_d = ST_XFER;
         end
         ST_XFER: begin
            if (hs) begin
               beat_d = beat_inc[8:0];
               if (user_tlast_o) begin
                  pkt_done_d = 1'b1;
                  len_err_d  = ovf_q || (beat_inc != exp_beats);
                  ptr_d      = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);
                  grant_d    = '0;
                  beat_d     = '0;
                  ovf_d      = 1'b0;
                  state_d    = ST_IDLE;
               end else if (!ovf_q && (beat_inc == exp_beats)) begin
                  // Overrun is flagged once; the packet still runs to its tlast.
                  len_err_d = 1'b1;
                  ovf_d     = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge log_clk or negedge log_rst_n) begin
      if (!log_rst_n) begin
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         gidx_q     <= '0;
         grant_q    <= '0;
         addr_q     <= '0;
         ftype_q    <= '0;
         ttype_q    <= '0;
         tsize_q    <= '0;
         beat_q     <= '0;
         ovf_q      <= 1'b0;
         len_err_q  <= 1'b0;
         pkt_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         gidx_q     <= gidx_d;
         grant_q    <= grant_d;
         addr_q     <= addr_d;
         ftype_q    <= ftype_d;
         ttype_q    <= ttype_d;
         tsize_q    <= tsize_d;
         beat_q     <= beat_d;
         ovf_q      <= ovf_d;
         len_err_q  <= len_err_d;
         pkt_done_q <= pkt_done_d;
      end
   end

   assign grant_o      = grant_q;
   assign user_addr_o  = addr_q;
   assign user_ftype_o = ftype_q;
   assign user_ttype_o = ttype_q;
   assign user_tsize_o = tsize_q;
   assign len_err_o    = len_err_q;
   assign pkt_done_o   = pkt_done_q;

endmodule
`default_nettype wire

// File: doc/srio_nwr_arbiter.md
# srio_nwr_arbiter

Round-robin arbiter that shares the single SRIO user request port (header + 64-bit AXI-stream payload) among NUM_REQ packet generators. It waits for the core to report `nwr_ready_in` with `nwr_busy_in` low, grants one requester, and holds that requester's header stable. It then forwards that requester's payload stream until the `tlast` handshake and checks the beat count against the declared size. It sits between the user-logic packet generators and the SRIO logical-layer user interface.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters, 2..8.

Ports (vectors indexed per requester i, packed LSB-first):
- log_clk  in  1  logical-layer clock; the block's only clock.
- log_rst_n  in  1  reset, asynchronous, active-low.
- nwr_ready_in  in  1  core can accept a new NWRITE.
- nwr_busy_in  in  1  core busy; no new grant while high.
- req_valid_i  in  NUM_REQ  requester i has a packet pending; must stay high until its grant.
- req_addr_i  in  34*NUM_REQ  target address.
- req_ftype_i / req_ttype_i  in  4*NUM_REQ each  packet type.
- req_tsize_i  in  12*NUM_REQ  byte count minus 1.
- req_tdata_i  in  64*NUM_REQ  payload.
- req_tvalid_i, req_tlast_i  in  NUM_REQ each  payload valid / last beat.
- req_tkeep_i  in  8*NUM_REQ  byte enables.
- req_tready_o  out  NUM_REQ  payload ready; only the granted bit can be high.
- grant_o  out  NUM_REQ  one-hot grant, held for the whole packet.
- user_addr_o 34, user_ftype_o 4, user_ttype_o 4, user_tsize_o 12  out  registered header of the granted requester.
- user_tdata_o 64, user_tkeep_o 8, user_tvalid_o 1, user_tlast_o 1  out  forwarded payload.
- user_tready_in  in  1  core payload ready.
- len_err_o  out  1  one-cycle pulse on a beat-count mismatch.
- pkt_done_o  out  1  one-cycle pulse when a packet completes.

## Operation
- States: IDLE, GRANT, XFER. Any undefined encoding returns to IDLE.
- IDLE: if `nwr_ready_in && !nwr_busy_in && |req_valid_i`, pick the winner and go to GRANT.
  - Winner = first set bit at or after `ptr`, searching upward with wrap.
  - Latch its index and its addr/ftype/ttype/tsize into the output header registers.
  - Set `grant_o` one-hot.
- GRANT: one cycle so the header is stable before data; then go to XFER.
- XFER: payload path is combinational.
  - `user_tdata/tkeep/tvalid/tlast_o` = granted requester's inputs.
  - `req_tready_o[g] = user_tready_in`; all other bits 0.
  - Beat counter (9 bits) increments on each handshake (`user_tvalid_o && user_tready_in`).
  - Expected beats = `tsize[11:3] + 1`, from the latched tsize (bytes = tsize+1).
  - On the `tlast` handshake: pulse `pkt_done_o`; set `ptr = g+1 mod NUM_REQ`; clear `grant_o`; go to IDLE.
  - If the beat count including this beat ≠ expected, also pulse `len_err_o`.
  - If the counter reaches expected beats and `tlast` is low on that beat, pulse `len_err_o` and keep forwarding until `tlast`; the packet is not truncated.
- `nwr_ready_in`/`nwr_busy_in` are sampled only in IDLE; changes during GRANT/XFER are ignored.
- A requester dropping `req_valid_i` after its grant has no effect; the transfer ends only on `tlast`.

## Timing
- Reset values (async on `log_rst_n` low):
  - state IDLE, `ptr` 0, beat count 0.
  - `grant_o` 0, `req_tready_o` 0, header outputs 0, `user_tsize_o` 0.
  - `user_tvalid_o` 0, `user_tlast_o` 0, `user_tkeep_o` 0, `len_err_o` 0, `pkt_done_o` 0.
- Latency: request seen in IDLE at cycle N; `grant_o` and header valid at N+1 (GRANT); first payload beat can handshake at N+2.
- Back-to-back packets: the `tlast` handshake at cycle M leaves XFER; IDLE at M+1; next grant at M+2. Minimum 2 idle cycles between packets.
- Outside XFER: `user_tvalid_o` and all `req_tready_o` are 0.
- Reset asserted mid-packet aborts immediately; no `pkt_done_o` or `len_err_o` pulse.

## Structure
- Package `srio_user_pkg` holds:
  - FTYPE_NWRITE=4'h5, FTYPE_SWRITE=4'h6, TTYPE_NWRITE=4'h4, TTYPE_NWRITE_R=4'h5.
  - The state enum.
  - `beats_from_tsize` function.
- Sub-module `rr_pick`: combinational, takes the req vector and `ptr`, returns the one-hot winner and its index.

## Test plan
- Single requester 1, tsize=255 (32 beats), `user_tready_in` always 1 -> `grant_o`=4'b0010 one cycle after the request; header equals req1's; 32 beats forwarded; `pkt_done_o` pulses with `len_err_o`=0.
- All 4 requesting continuously -> grants in order 0,1,2,3,0; `grant_o` never has two bits set.
- tsize=250 (32 beats) but `tlast` on beat 31 -> `len_err_o` pulses on beat 31; state returns to IDLE.
- `user_tready_in` toggled 1010… -> granted `req_tready_o` mirrors it; non-granted bits stay 0; no beat is lost or duplicated.
- `nwr_busy_in`=1 with requests pending -> no grant; after busy drops, grant two cycles later. Toggling busy mid-XFER has no effect.
- `log_rst_n` pulsed low at beat 10 -> all outputs at reset values; next grant goes to requester 0.
